sevenseg_scan_reader: RTL and testbench

Receive-side monitor for the multiplexed eight-digit seven-segment bus driven by `system` (anode/cathode outputs).
- Samples the active-low anode and cathode lines.
- Waits until each digit's pattern has been stable long enough, then decodes it to a hex nibble.
- Assembles a 32-bit value plus decimal points.
- Publishes one complete frame per full scan.

Used in the system-level bench and on-board loopback to check display output without visual inspection.

---
 rtl/sevenseg_pkg.sv | 31 +++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/sevenseg_scan_reader.sv | 148 ++++++++++++++
 tb/tb_sevenseg_scan_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit7 = dp, off) and bus helpers.
package sevenseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // True when exactly one anode line is pulled low.
    function automatic logic is_one_hot_low(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] sel;
        sel = ~an;
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of an active-low segment pattern (a..g) to a hex nibble.
module seg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] c_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    // Match against the shared glyph table; anything else is flagged invalid.
    always_comb begin
        valid_o  = 1'b1;
        nibble_o = 4'h0;
        case (c_i)
            SEG_0[6:0]: nibble_o = 4'h0;
            SEG_1[6:0]: nibble_o = 4'h1;
            SEG_2[6:0]: nibble_o = 4'h2;
            SEG_3[6:0]: nibble_o = 4'h3;
            SEG_4[6:0]: nibble_o = 4'h4;
            SEG_5[6:0]: nibble_o = 4'h5;
            SEG_6[6:0]: nibble_o = 4'h6;
            SEG_7[6:0]: nibble_o = 4'h7;
            SEG_8[6:0]: nibble_o = 4'h8;
            SEG_9[6:0]: nibble_o = 4'h9;
            SEG_A[6:0]: nibble_o = 4'hA;
            SEG_B[6:0]: nibble_o = 4'hB;
            SEG_C[6:0]: nibble_o = 4'hC;
            SEG_D[6:0]: nibble_o = 4'hD;
            SEG_E[6:0]: nibble_o = 4'hE;
            SEG_F[6:0]: nibble_o = 4'hF;
            default:    valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// Receive-side monitor for a multiplexed 8-digit seven-segment bus. Captures each digit once
// per stable dwell and publishes a 32-bit value plus decimal points per completed scan.
// Build option: SEVENSEG_STRICT_EN suppresses publication of frames holding undecodable digits.
module sevenseg_scan_reader
    import sevenseg_pkg::*;
#(
    parameter int unsigned                STABLE_CYCLES = 4,
    parameter logic [NUM_DIGITS-1:0]      DIGIT_MASK    = 8'hFF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_DIGITS-1:0]         an_in,
    input  logic [7:0]                    c_in,
    output logic [4*NUM_DIGITS-1:0]       value,
    output logic [NUM_DIGITS-1:0]         dp,
    output logic                          frame_valid,
    output logic [NUM_DIGITS-1:0]         seen,
    output logic                          bad_pattern
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   an_q, prev_an_q;
    logic [7:0]              c_q, prev_c_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, dp_q, dp_d, seen_q, seen_d, seen_new;
    logic                    fv_q, fv_d, bad_q, bad_d;
    logic                    one_hot, same, hold_sat, capture, publish;
    logic                    glyph_valid;
    logic [3:0]              glyph_nibble;
`ifdef SEVENSEG_STRICT_EN
    logic                    frame_bad_q, frame_bad_d;
`endif

    seg_glyph_decode u_decode (
        .c_i      (c_q[6:0]),
        .valid_o  (glyph_valid),
        .nibble_o (glyph_nibble)
    );

    assign one_hot  = is_one_hot_low(an_q);
    assign same     = (an_q == prev_an_q) && (c_q == prev_c_q);
    // A saturated counter holding the same pattern must not capture again.
    assign hold_sat = one_hot && same && (cnt_q == StableCnt);
    assign capture  = one_hot && (cnt_d == StableCnt) && !hold_sat;
    assign seen_new = seen_q | ~an_q;

    // Stability counter: count identical one-hot samples, saturating at StableCnt.
    always_comb begin
        cnt_d = 8'd0;
        if (one_hot) begin
            if (same) begin
                cnt_d = (cnt_q == StableCnt) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd1;
            end
        end
    end

    // Shadow capture, frame completion and sticky error tracking.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        seen_d      = seen_q;
        value_d     = value_q;
        dp_d        = dp_q;
        fv_d        = 1'b0;
        bad_d       = bad_q;
`ifdef SEVENSEG_STRICT_EN
        frame_bad_d = frame_bad_q;
        publish     = !(frame_bad_q || !glyph_valid);
`else
        publish     = 1'b1;
`endif
        if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!an_q[i]) begin
                    shadow_d[4*i +: 4] = glyph_nibble;
                    shadow_dp_d[i]     = ~c_q[7];
                end
            end
            if (!glyph_valid) begin
                bad_d = 1'b1;
`ifdef SEVENSEG_STRICT_EN
                frame_bad_d = 1'b1;
`endif
            end
            if ((seen_new & DIGIT_MASK) == DIGIT_MASK) begin
                seen_d = '0;
`ifdef SEVENSEG_STRICT_EN
                frame_bad_d = 1'b0;
`endif
                if (publish) begin
                    value_d = shadow_d;
                    dp_d    = shadow_dp_d;
                    fv_d    = 1'b1;
                end
            end else begin
                seen_d = seen_new;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_q        <= SEG_BLANK;
            c_q         <= SEG_BLANK;
            prev_an_q   <= SEG_BLANK;
            prev_c_q    <= SEG_BLANK;
            cnt_q       <= 8'd0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            seen_q      <= '0;
            value_q     <= '0;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            bad_q       <= 1'b0;
`ifdef SEVENSEG_STRICT_EN
            frame_bad_q <= 1'b0;
`endif
        end else begin
            an_q        <= an_in;
            c_q         <= c_in;
            prev_an_q   <= an_q;
            prev_c_q    <= c_q;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seen_q      <= seen_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            bad_q       <= bad_d;
`ifdef SEVENSEG_STRICT_EN
            frame_bad_q <= frame_bad_d;
`endif
        end
    end

    assign value       = value_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign seen        = seen_q;
    assign bad_pattern = bad_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Scoreboard bench for sevenseg_scan_reader: dwell-level reference model feeds an expected-frame
// queue; a monitor pops and compares on every frame_valid pulse.
module tb_sevenseg_scan_reader;

    localparam int STABLE = 4;
    localparam logic [7:0] MASK = 8'hFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  an_in, c_in;
    logic [31:0] value;
    logic [7:0]  dp, seen;
    logic        frame_valid, bad_pattern;

    sevenseg_scan_reader #(
        .STABLE_CYCLES (STABLE),
        .DIGIT_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .an_in       (an_in),
        .c_in        (c_in),
        .value       (value),
        .dp          (dp),
        .frame_valid (frame_valid),
        .seen        (seen),
        .bad_pattern (bad_pattern)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  d;
    } frame_t;

    frame_t      exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  glyph [16];

    // Reference model state: what the display has committed so far.
    logic [3:0]  m_nib [8];
    logic [7:0]  m_dp, m_seen, run_an, run_c;
    logic        m_bad, m_frame_bad;
    int          run_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] c);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] g;
            g = glyph[k];
            if (g[6:0] == c) return {1'b1, 4'(k)};
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
        m_dp = 8'h00; m_seen = 8'h00; m_bad = 1'b0; m_frame_bad = 1'b0;
        run_an = 8'hFF; run_c = 8'hFF; run_len = 0;
    endtask

    // One capture of digit idx with pattern c, including frame completion.
    task automatic model_capture(input int idx, input logic [7:0] c);
        logic [4:0] dec;
        frame_t     f;
        dec = ref_decode(c[6:0]);
        m_nib[idx] = dec[4] ? dec[3:0] : 4'h0;
        m_dp[idx]  = ~c[7];
        if (!dec[4]) begin
            m_bad = 1'b1;
            m_frame_bad = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if ((m_seen & MASK) == MASK) begin
            for (int k = 0; k < 8; k++) f.v[4*k +: 4] = m_nib[k];
            f.d = m_dp;
`ifdef SEVENSEG_STRICT_EN
            if (!m_frame_bad) exp_q.push_back(f);
`else
            exp_q.push_back(f);
`endif
            m_seen = 8'h00;
            m_frame_bad = 1'b0;
        end
    endtask

    // A dwell of len cycles captures if the run of identical one-hot samples crosses STABLE.
    task automatic model_dwell(input logic [7:0] an, input logic [7:0] c, input int len);
        int prior;
        if ($countones(~an) == 1) begin
            prior = (an == run_an && c == run_c) ? run_len : 0;
            run_len = prior + len;
            if (prior < STABLE && prior + len >= STABLE) begin
                for (int k = 0; k < 8; k++) if (!an[k]) model_capture(k, c);
            end
        end else begin
            run_len = 0;
        end
        run_an = an;
        run_c  = c;
    endtask

    task automatic dwell(input logic [7:0] an, input logic [7:0] c, input int len);
        model_dwell(an, c, len);
        an_in = an;
        c_in  = c;
        repeat (len) @(negedge clk);
    endtask

    task automatic settle_check(input string name);
        dwell(8'hFF, 8'hFF, 3);
        chk(name, {56'd0, seen}, {56'd0, m_seen});
    endtask

    task automatic do_reset();
        dwell(8'hFF, 8'hFF, 3);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        chk("rst_value", {32'd0, value}, 64'd0);
        chk("rst_seen", {56'd0, seen}, 64'd0);
        chk("rst_bad", {63'd0, bad_pattern}, 64'd0);
    endtask

    task automatic scan(input logic [31:0] val, input logic [7:0] dpv, input int short_dig,
                        input int odd_dig, input logic [7:0] odd_c);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] an, c, g;
            g  = glyph[val[4*i +: 4]];
            an = ~(8'h01 << i);
            c  = {~dpv[i], g[6:0]};
            if (i == odd_dig) c = odd_c;
            dwell(an, c, (i == short_dig) ? STABLE - 1 : STABLE);
        end
    endtask

    // Monitor: every published frame must match the oldest expectation.
    logic prev_fv = 1'b0;
    always @(negedge clk) begin
        if (resetn && frame_valid) begin
            chk("fv_one_cycle", {63'd0, prev_fv}, 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got value=%h dp=%h expected no frame", value, dp);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("frame_value", {32'd0, value}, {32'd0, f.v});
                chk("frame_dp", {56'd0, dp}, {56'd0, f.d});
            end
        end
        prev_fv <= frame_valid;
    end

    initial begin
        glyph[0]  = 8'hC0; glyph[1]  = 8'hF9; glyph[2]  = 8'hA4; glyph[3]  = 8'hB0;
        glyph[4]  = 8'h99; glyph[5]  = 8'h92; glyph[6]  = 8'h82; glyph[7]  = 8'hF8;
        glyph[8]  = 8'h80; glyph[9]  = 8'h90; glyph[10] = 8'h88; glyph[11] = 8'h83;
        glyph[12] = 8'hC6; glyph[13] = 8'hA1; glyph[14] = 8'h86; glyph[15] = 8'h8E;
        model_reset();
        resetn = 1'b0;
        an_in  = 8'hFF;
        c_in   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("init_value", {32'd0, value}, 64'd0);
        chk("init_dp", {56'd0, dp}, 64'd0);
        chk("init_fv", {63'd0, frame_valid}, 64'd0);
        chk("init_seen", {56'd0, seen}, 64'd0);
        chk("init_bad", {63'd0, bad_pattern}, 64'd0);
        resetn = 1'b1;

        // Plain full scan.
        scan(32'h1234ABCD, 8'h00, 8, 8, 8'h00);
        settle_check("scan_seen");
        chk("scan_frames_out", 64'(exp_q.size()), 64'd0);

        // Short dwell on digit 3, then a full scan completes the frame.
        scan(32'h1234ABCD, 8'h00, 3, 8, 8'h00);
        settle_check("short_seen");
        scan(32'h1234ABCD, 8'h00, 8, 8, 8'h00);
        settle_check("rescan_seen");

        // Two anodes low never captures.
        do_reset();
        dwell(8'hFC, 8'hC0, 10);
        settle_check("illegal_seen");

        // Decimal point on digit 0.
        scan(32'h0, 8'h01, 8, 8, 8'h00);
        settle_check("dp_seen");

        // Undecodable pattern on digit 5.
        scan(32'h0, 8'h00, 8, 5, 8'hFE);
        settle_check("badpat_seen");
        chk("badpat_flag", {63'd0, bad_pattern}, {63'd0, m_bad});

        // Reset mid-frame then a fresh scan.
        for (int i = 0; i < 4; i++) dwell(~(8'h01 << i), 8'h80, STABLE);
        do_reset();
        scan(32'h87654321, 8'h00, 8, 8, 8'h00);
        settle_check("post_rst_seen");

        // Randomized dwells.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] an, c, g;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 75) an = ~(8'h01 << $urandom_range(0, 7));
            else if (r < 85) an = 8'hFF;
            else an = 8'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                g = glyph[$urandom_range(0, 15)];
                c = {1'($urandom), g[6:0]};
            end else begin
                c = 8'($urandom);
            end
            dwell(an, c, int'($urandom_range(1, 6)));
        end
        settle_check("rand_seen");
        chk("rand_bad", {63'd0, bad_pattern}, {63'd0, m_bad});

        repeat (STABLE + 4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
